washer_plant_model: RTL and testbench

- Sensor/actuator-side model of the washing machine; the counterpart of the wash controller FSM.
- Consumes the controller's actuator commands (fill/drain valves, motor, door lock, wash-phase flags) and produces the sensor and timer inputs the controller waits on: filled, drained, detergent_added, cycle_timeout, spin_timeout.
- Used in closed-loop simulation and on the FPGA demo board in place of real hardware; also flags illegal command combinations.

---
 rtl/washer_plant_model.sv | 143 ++++++++++++++
 tb/tb_washer_plant_model.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/washer_plant_model.sv
// Plant-side stand-in for the washer: turns valve/motor/lock commands into level, dispenser and timer sensors.
// Outputs are decoded from registers, so they show each tick one clk later; there is no handshake and no backpressure.
module washer_plant_model #(
   parameter int FULL_LEVEL  = 8,
   parameter int LEVEL_W     = 4,
   parameter int CYCLE_TICKS = 20,
   parameter int SPIN_TICKS  = 12,
   parameter int DET_TICKS   = 3,
   parameter int TIMER_W     = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   input  logic               fill_value_on,
   input  logic               drain_value_on,
   input  logic               motor_on,
   input  logic               door_lock,
   input  logic               soap_wash,
   input  logic               water_wash,
   output logic               filled,
   output logic               drained,
   output logic               detergent_added,
   output logic               cycle_timeout,
   output logic               spin_timeout,
   output logic               fault,
   output logic [LEVEL_W-1:0] level
);

   localparam logic [LEVEL_W-1:0] LP_FULL = LEVEL_W'(FULL_LEVEL);
   localparam logic [TIMER_W-1:0] LP_CYC  = TIMER_W'(CYCLE_TICKS);
   localparam logic [TIMER_W-1:0] LP_SPIN = TIMER_W'(SPIN_TICKS);
   localparam logic [TIMER_W-1:0] LP_DET  = TIMER_W'(DET_TICKS);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DISPENSE,
      ST_DONE
   } disp_state_t;

   disp_state_t          r_state;
   disp_state_t          w_state_nxt;
   logic [LEVEL_W-1:0]   r_level;
   logic [TIMER_W-1:0]   r_cyc_cnt;
   logic [TIMER_W-1:0]   r_spin_cnt;
   logic [TIMER_W-1:0]   r_det_cnt;
   logic [TIMER_W-1:0]   w_det_cnt_nxt;
   logic                 r_fault;
   logic                 w_filled;
   logic                 w_drained;
   logic                 w_illegal;

   assign w_filled  = (r_level == LP_FULL);
   assign w_drained = (r_level == '0);
   assign w_illegal = (fill_value_on & drain_value_on) |
                      (motor_on & ~door_lock) |
                      (fill_value_on & ~door_lock);

   // Opposing valves cancel; the level saturates at both ends.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_level <= '0;
      end else if (tick) begin
         if (fill_value_on && !drain_value_on && (r_level < LP_FULL))
            r_level <= r_level + LEVEL_W'(1);
         else if (drain_value_on && !fill_value_on && (r_level != '0))
            r_level <= r_level - LEVEL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cyc_cnt <= '0;
      end else if (!motor_on) begin
         r_cyc_cnt <= '0;
      end else if (tick && door_lock && (r_cyc_cnt < LP_CYC)) begin
         r_cyc_cnt <= r_cyc_cnt + TIMER_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_spin_cnt <= '0;
      end else if (!drain_value_on) begin
         r_spin_cnt <= '0;
      end else if (tick && water_wash && w_drained && (r_spin_cnt < LP_SPIN)) begin
         r_spin_cnt <= r_spin_cnt + TIMER_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_det_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_det_cnt <= w_det_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_det_cnt_nxt = r_det_cnt;
      case (r_state)
         ST_IDLE: begin
            if (door_lock && soap_wash && !water_wash && w_filled && !fill_value_on) begin
               w_state_nxt   = ST_DISPENSE;
               w_det_cnt_nxt = '0;
            end
         end
         ST_DISPENSE: begin
            // Opening the door abandons the load before the soap is in.
            if (!door_lock) begin
               w_state_nxt = ST_IDLE;
            end else if (tick) begin
               w_det_cnt_nxt = r_det_cnt + TIMER_W'(1);
               if (w_det_cnt_nxt >= LP_DET)
                  w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!door_lock)
               w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_fault <= 1'b0;
      else
         r_fault <= r_fault | w_illegal;
   end

   assign filled          = w_filled;
   assign drained         = w_drained;
   assign detergent_added = (r_state == ST_DONE);
   assign cycle_timeout   = (r_cyc_cnt == LP_CYC);
   assign spin_timeout    = (r_spin_cnt == LP_SPIN);
   assign fault           = r_fault;
   assign level           = r_level;

endmodule

// File: tb/tb_washer_plant_model.sv
// Closed-loop bench for washer_plant_model: directed scenarios plus randomized command segments against a tick-level reference.
module tb_washer_plant_model;

   localparam int FULL = 8;
   localparam int CYC  = 20;
   localparam int SPIN = 12;
   localparam int DET  = 3;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       tick  = 1'b0;
   logic       fill  = 1'b0;
   logic       drain = 1'b0;
   logic       motor = 1'b0;
   logic       lock  = 1'b0;
   logic       soap  = 1'b0;
   logic       ww    = 1'b0;
   logic       filled, drained, det_added, cyc_to, spin_to, fault;
   logic [3:0] level;

   washer_plant_model #(
      .FULL_LEVEL(FULL), .LEVEL_W(4), .CYCLE_TICKS(CYC),
      .SPIN_TICKS(SPIN), .DET_TICKS(DET), .TIMER_W(8)
   ) dut (
      .clk(clk), .reset(reset), .tick(tick),
      .fill_value_on(fill), .drain_value_on(drain), .motor_on(motor),
      .door_lock(lock), .soap_wash(soap), .water_wash(ww),
      .filled(filled), .drained(drained), .detergent_added(det_added),
      .cycle_timeout(cyc_to), .spin_timeout(spin_to), .fault(fault),
      .level(level)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit filled;
      bit drained;
      bit det;
      bit cto;
      bit sto;
      bit fault;
      int level;
   } exp_t;

   exp_t exp_q[$];
   event ev_push;
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference state: plain integers, dispenser as "ticks still to go" (-1 = not dispensing).
   int m_level, m_motor_ticks, m_spin_ticks, m_det_left;
   bit m_det_done, m_fault;

   function automatic int imin(int a, int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int imax(int a, int b);
      return (a > b) ? a : b;
   endfunction

   function void model_reset();
      m_level = 0; m_motor_ticks = 0; m_spin_ticks = 0;
      m_det_left = -1; m_det_done = 0; m_fault = 0;
   endfunction

   function void model_edge();
      int  lvl_before;
      bit  full_before;
      lvl_before  = m_level;
      full_before = (m_level == FULL);
      if (tick && fill && !drain) m_level = imin(m_level + 1, FULL);
      if (tick && drain && !fill) m_level = imax(m_level - 1, 0);
      if (!motor) m_motor_ticks = 0;
      else if (tick && lock) m_motor_ticks = imin(m_motor_ticks + 1, CYC);
      if (!drain) m_spin_ticks = 0;
      else if (tick && ww && lvl_before == 0) m_spin_ticks = imin(m_spin_ticks + 1, SPIN);
      if (m_det_done) begin
         if (!lock) m_det_done = 0;
      end else if (m_det_left >= 0) begin
         if (!lock) m_det_left = -1;
         else if (tick) begin
            m_det_left--;
            if (m_det_left == 0) begin
               m_det_done = 1;
               m_det_left = -1;
            end
         end
      end else if (lock && soap && !ww && full_before && !fill) begin
         m_det_left = DET;
      end
      if ((fill && drain) || (motor && !lock) || (fill && !lock)) m_fault = 1;
   endfunction

   function exp_t model_out();
      exp_t e;
      e.filled  = (m_level == FULL);
      e.drained = (m_level == 0);
      e.det     = m_det_done;
      e.cto     = (m_motor_ticks == CYC);
      e.sto     = (m_spin_ticks == SPIN);
      e.fault   = m_fault;
      e.level   = m_level;
      return e;
   endfunction

   task automatic push_exp();
      exp_q.push_back(model_out());
      -> ev_push;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // Monitor: every pushed expectation is compared 1 time unit later.
   initial begin
      exp_t e;
      forever begin
         @(ev_push);
         #1;
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("level",           32'(level),     32'(e.level));
            chk("filled",          32'(filled),    32'(e.filled));
            chk("drained",         32'(drained),   32'(e.drained));
            chk("detergent_added", 32'(det_added), 32'(e.det));
            chk("cycle_timeout",   32'(cyc_to),    32'(e.cto));
            chk("spin_timeout",    32'(spin_to),   32'(e.sto));
            chk("fault",           32'(fault),     32'(e.fault));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      if (!reset) model_reset();
      else model_edge();
      push_exp();
      @(negedge clk);
   endtask

   // Reset asserted mid low-phase: outputs must follow before any clock edge.
   task automatic async_reset();
      #2;
      reset = 1'b0;
      model_reset();
      push_exp();
      #2;
      step();
      reset = 1'b1;
   endtask

   task automatic set_cmd(input bit f, input bit d, input bit m, input bit l, input bit s, input bit w);
      fill = f; drain = d; motor = m; lock = l; soap = s; ww = w;
   endtask

   initial begin
      int len, mode;
      #1;
      reset = 1'b0;
      model_reset();
      push_exp();
      @(negedge clk);
      step();
      reset = 1'b1;
      tick  = 1'b1;

      set_cmd(1, 0, 0, 1, 0, 0); repeat (10) step();
      set_cmd(0, 0, 0, 1, 1, 0); repeat (5) step();
      set_cmd(0, 0, 1, 1, 0, 0); repeat (22) step();
      motor = 1'b0; step();
      motor = 1'b1; repeat (21) step();
      motor = 1'b0; step();
      set_cmd(0, 1, 0, 1, 0, 1); repeat (22) step();
      drain = 1'b0; step();
      lock = 1'b0; step();

      set_cmd(1, 0, 0, 1, 0, 0); repeat (4) step();
      set_cmd(1, 1, 0, 1, 0, 0); repeat (2) step();
      set_cmd(0, 0, 0, 1, 0, 0); repeat (2) step();
      async_reset();
      set_cmd(0, 0, 1, 0, 0, 0); repeat (2) step();
      set_cmd(0, 0, 0, 0, 0, 0); step();
      async_reset();

      set_cmd(1, 0, 0, 1, 0, 0); repeat (9) step();
      set_cmd(0, 0, 0, 1, 1, 0); tick = 1'b0; step();
      set_cmd(0, 1, 0, 1, 0, 0); tick = 1'b1; repeat (2) step();
      async_reset();

      for (int seg = 0; seg < 90; seg++) begin
         len  = $urandom_range(3, 30);
         mode = $urandom_range(0, 9);
         case (mode)
            0: set_cmd(1, 0, 0, 1, 0, 0);
            1: set_cmd(0, 1, 0, 1, 0, $urandom_range(0, 1) != 0);
            2: set_cmd(0, 0, 1, 1, 0, 0);
            3: set_cmd(0, 0, 0, 1, 1, 0);
            4: set_cmd(0, 0, 0, 0, 0, 0);
            5: set_cmd(0, 1, 0, 1, 0, 1);
            6: set_cmd($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                       $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                       $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
            default: set_cmd(0, 0, 0, 1, 0, 0);
         endcase
         repeat (len) begin
            tick = ($urandom_range(0, 3) != 0);
            step();
         end
         if (seg % 20 == 19) async_reset();
      end

      #3;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
